// File: rtl/mult_share_pkg.sv
// ============================================================================
// Module : mult_share_pkg
// Desc   : Shared widths, id-width helper and response record for the
//          shared-multiplier arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_share_pkg;

    localparam int OP_W     = 4;
    localparam int PROD_W   = 8;
    localparam int MAX_ID_W = 3;

    function automatic int id_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    // Sized for the largest supported requester count (8).
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [PROD_W-1:0]   prod;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/booth_radix4_multiplier.sv
// ============================================================================
// Module : booth_radix4_multiplier
// Desc   : Combinational radix-4 Booth multiplier, signed OP_W x OP_W -> PROD_W.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module booth_radix4_multiplier
    import mult_share_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] p_o
);

    localparam int C_NDIG = OP_W / 2;

    logic [OP_W:0]     w_b_ext;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_sum;

    assign w_b_ext = {b_i, 1'b0};
    assign w_a_ext = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};

    // Modulo-2^PROD_W accumulation is exact because the true product always fits.
    always_comb begin
        w_sum = '0;
        for (int d = 0; d < C_NDIG; d++) begin
            case (w_b_ext[2*d +: 3])
                3'b001, 3'b010: w_sum = w_sum + (w_a_ext << (2*d));
                3'b011:         w_sum = w_sum + (w_a_ext << (2*d + 1));
                3'b100:         w_sum = w_sum - (w_a_ext << (2*d + 1));
                3'b101, 3'b110: w_sum = w_sum - (w_a_ext << (2*d));
                default:        w_sum = w_sum;
            endcase
        end
    end

    assign p_o = w_sum;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Desc   : Combinational round-robin pick: first request at or after ptr_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req_i,
    input  logic [id_w(N)-1:0]  ptr_i,
    input  logic                en_i,
    output logic [N-1:0]        gnt_o,
    output logic [id_w(N)-1:0]  gnt_idx_o
);

    localparam int            IW  = id_w(N);
    localparam logic [IW:0]   C_N = (IW+1)'(N);

    logic [IW:0] w_cand;
    logic        w_found;

    // gnt_idx_o is meaningful whenever any request is set; gnt_o is gated by en_i.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (w_cand >= C_N) begin
                w_cand = w_cand - C_N;
            end
            if (!w_found && req_i[w_cand[IW-1:0]]) begin
                w_found   = 1'b1;
                gnt_idx_o = w_cand[IW-1:0];
            end
        end
        if (en_i && w_found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
// ============================================================================
// Module : mult_share_arbiter
// Desc   : Round-robin sharing of one Booth multiplier across N_REQ requesters
//          with a single registered, backpressured response slot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*OP_W-1:0]    req_a,
    input  logic [N_REQ*OP_W-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [id_w(N_REQ)-1:0]   rsp_id,
    output logic [PROD_W-1:0]        rsp_p,
    output logic [CNT_W-1:0]         op_count
);

    localparam int IDW = id_w(N_REQ);

    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_q, rsp_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic              w_can_accept;
    logic              w_arb_en;
    logic              w_accept;
    logic [N_REQ-1:0]  w_gnt;
    logic [IDW-1:0]    w_gnt_idx;
    logic [OP_W-1:0]   w_op_a;
    logic [OP_W-1:0]   w_op_b;
    logic [PROD_W-1:0] w_prod;
    logic              w_unused_id;

    // The slot may be refilled in the same cycle it is drained.
    assign w_can_accept = !rsp_valid_q || rsp_ready;
    assign w_arb_en     = w_can_accept && !rst;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .en_i      (w_arb_en),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_op_a = req_a[i*OP_W +: OP_W];
                w_op_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    booth_radix4_multiplier u_mult (
        .a_i (w_op_a),
        .b_i (w_op_b),
        .p_o (w_prod)
    );

    assign w_accept = |(req_valid & w_gnt);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;
        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_d.id    = MAX_ID_W'(w_gnt_idx);
            rsp_d.prod  = w_prod;
            rr_ptr_d    = (w_gnt_idx == IDW'(N_REQ-1)) ? '0 : w_gnt_idx + IDW'(1);
            if (op_count_q != '1) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready   = w_gnt;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_q.id[IDW-1:0];
    assign rsp_p       = rsp_q.prod;
    assign op_count    = op_count_q;
    assign w_unused_id = ^rsp_q.id;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ============================================================================
// Module : tb_mult_share_arbiter
// Desc   : Scoreboard bench for mult_share_arbiter against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*4-1:0]  req_a = '0;
    logic [N*4-1:0]  req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_p;
    logic [CW-1:0]   op_count;

    mult_share_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] p;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_rr     = 0;
    int   m_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference arbitration: first valid requester at or after m_rr, wrapping.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic cyc(input logic r, input logic [N-1:0] v,
                       input logic [N*4-1:0] a, input logic [N*4-1:0] b, input logic rr);
        int         g;
        logic [N-1:0] exp_rdy;
        int         sa, sb;
        @(negedge clk);
        rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #2;
        g = model_grant(v);
        exp_rdy = (!r && (q.size() == 0 || rr) && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_rr  = 0;
            m_cnt = 0;
        end else if (exp_rdy != '0) begin
            sa = int'($signed(a[g*4 +: 4]));
            sb = int'($signed(b[g*4 +: 4]));
            q.push_back('{id: g, p: 8'(sa * sb)});
            m_rr = (g + 1) % N;
            if (m_cnt != (1 << CW) - 1) m_cnt++;
        end
    endtask

    // Monitor: slot contents must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
            if (rsp_valid && q.size() != 0) begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
                if (rsp_ready && !rst) void'(q.pop_front());
            end
        end
    end

    function automatic logic [N*4-1:0] fill(input int base, input logic [3:0] same_b, input bit is_b);
        logic [N*4-1:0] x;
        for (int i = 0; i < N; i++) x[i*4 +: 4] = is_b ? same_b : 4'(base + i);
        return x;
    endfunction

    logic [N*4-1:0] va, vb, vm8;

    initial begin
        vm8 = '0;
        for (int i = 0; i < N; i++) vm8[i*4 +: 4] = 4'h8;

        cyc(1'b1, '0, '0, '0, 1'b1);
        // Single requester, -8 * -8
        cyc(1'b0, 4'b0001, vm8, vm8, 1'b1);
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        // All valid, A=i+1, B=-3, back-to-back
        va = fill(1, 4'h0, 1'b0);
        vb = fill(0, 4'hD, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 4'b1111, va, vb, 1'b1);
        // Stall three cycles then release
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'b1111, va, vb, 1'b0);
        cyc(1'b0, 4'b1111, va, vb, 1'b1);
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        // Pointer past requester 1, only 0 and 3 valid
        cyc(1'b1, '0, '0, '0, 1'b1);
        cyc(1'b0, 4'b0010, va, vb, 1'b1);
        cyc(1'b0, 4'b1001, va, vb, 1'b1);
        cyc(1'b0, 4'b1001, va, vb, 1'b1);
        // Exhaustive operand sweep through requester 2
        cyc(1'b1, '0, '0, '0, 1'b1);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                va = '0; vb = '0;
                va[11:8] = 4'(x);
                vb[11:8] = 4'(y);
                cyc(1'b0, 4'b0100, va, vb, 1'b1);
            end
        end
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        // Reset while a response is stalled
        cyc(1'b0, 4'b0001, va, vb, 1'b0);
        cyc(1'b0, 4'b1111, va, vb, 1'b0);
        cyc(1'b1, 4'b1111, va, vb, 1'b0);
        cyc(1'b0, 4'b1010, va, vb, 1'b1);
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        // Randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            cyc(($urandom_range(0, 199) == 0), N'($urandom), N*4'($urandom), N*4'($urandom),
                ($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        cyc(1'b0, 4'b0000, '0, '0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one combinational booth_radix4_multiplier (4-bit signed operands, 8-bit signed product) among N_REQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter picks one request per cycle, and its product is captured in a single registered response slot. The response carries the requester ID and supports backpressure. The block sits between the multiplier-using clients and the shared datapath, and keeps a saturating count of completed operations.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept, one-hot or zero
req_a  input  N_REQ*4  packed signed multiplicands, requester i at [4i+3:4i]
req_b  input  N_REQ*4  packed signed multipliers, same packing
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer takes the response
rsp_id  output  $clog2(N_REQ)  index of the requester that produced rsp_p
rsp_p  output  8  signed product A*B
op_count  output  CNT_W  number of accepted operations, saturating

Behaviour:
- Reset (rst=1 at a clock edge):
  - Registered outputs: rsp_valid=0, rsp_id=0, rsp_p=0, op_count=0, internal rr_ptr=0.
  - req_ready is forced to all zeros combinationally while rst=1.
- can_accept = !rsp_valid || rsp_ready. The slot is free, or it is being drained in the same cycle.
- Grant:
  - The grant is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[i] = can_accept && granted(i).
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake on requester g (req_valid[g] && req_ready[g]) at a clock edge:
  - rsp_p <= booth product of req_a[g], req_b[g].
  - rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
  - op_count <= op_count+1, saturating at all-ones.
- Latency: the response is valid on the cycle after acceptance.
- Throughput: one operation per cycle while rsp_ready=1.
- Drain without a new accept (rsp_valid && rsp_ready, no handshake): rsp_valid <= 0. rsp_p and rsp_id hold their last values.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1, with no bubble.
- Stall (rsp_valid && !rsp_ready): req_ready=0 for all requesters. rsp_p, rsp_id and rsp_valid are held stable. rr_ptr and op_count are unchanged.
- No request valid: rr_ptr is unchanged and there is no state change apart from a drain.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- Arithmetic: signed two's complement throughout. -8*-8 = +64 fits 8 bits, so no overflow is possible.
- Reset mid-operation: a pending response is discarded without being delivered, and arbitration restarts from requester 0.
- Operand values are sampled only in the handshake cycle. Values while req_ready=0 are ignored.

Decomposition:
- Package mult_share_pkg:
  - OP_W=4, PROD_W=8.
  - Function id_w(n) returning $clog2(n), with a minimum of 1.
  - Typedef for the response record {id, product}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr, plus an enable. Outputs a one-hot gnt[N] and a binary gnt_idx.
- booth_radix4_multiplier is instantiated once, driven by a mux selected by gnt_idx.

Test Plan:
1. Only requester 0 valid, A=-8, B=-8, rsp_ready=1 -> req_ready=0001 in cycle 0. In cycle 1: rsp_valid=1, rsp_id=0, rsp_p=64 (0x40), op_count=1.
2. All four requesters valid continuously with A=i+1, B=-3, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. rsp_p sequence -3,-6,-9,-12,-3, with no idle cycles.
3. Response pending with rsp_ready=0 for 3 cycles, all requesters valid -> req_ready=0000 for all 3 cycles, and rsp_p/rsp_id unchanged. When rsp_ready=1, the next requester is accepted in that same cycle and rsp_valid stays 1.
4. After a grant to requester 1 (rr_ptr=2), only requesters 0 and 3 valid -> requester 3 granted first, then requester 0.
5. All 256 (A,B) pairs from -8..7 issued through requester 2 with rsp_ready=1 -> every rsp_p equals A*B, every rsp_id=2, and op_count=256 at the end.
6. Response stalled (rsp_valid=1, rsp_ready=0), then rst pulsed for 1 cycle -> next cycle rsp_valid=0 and op_count=0. With requesters 1 and 3 valid, the first grant afterwards is requester 1.
